conv_result_serializer: RTL and testbench

//  Consumer end of the conv result interface. Captures the flat result frame that conv presents
//  on data_out at its done pulse, then streams it back out one signed 2*word_length result per

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_result_serializer_rc_counter.sv | 35 +++
 rtl/conv_result_serializer.sv | 99 +++++++++
 tb/tb_conv_result_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv result path: result width, output-size math, FSM states.
package conv_pkg;

  function automatic int res_w(input int word_length);
    return 2 * word_length;
  endfunction

  localparam int RES_W = res_w(8);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int out_size(input int image_size, input int kernel_size);
    return image_size - (kernel_size - kernel_size % 2);
  endfunction

  // A one-entry axis still needs a 1-bit counter.
  function automatic int cnt_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/conv_result_serializer_rc_counter.sv
// Row/column raster counter with enable, clear, wrap and a last-position flag.
module rc_counter
  import conv_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int W    = cnt_width(SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(SIZE - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/conv_result_serializer.sv
// Captures a conv result frame on in_valid and streams it out one word per valid/ready beat.
// Optional build macro CONV_SER_RELU_EN clamps negative words to zero at the output.
module conv_result_serializer
  import conv_pkg::*;
#(
  parameter int  word_length = 8,
  parameter int  kernel_size = 5,
  parameter int  image_size  = 36,
  localparam int DATA_W      = res_w(word_length),
  localparam int OUT_SIZE    = out_size(image_size, kernel_size),
  localparam int CW          = cnt_width(OUT_SIZE),
  localparam int FRAME_W     = OUT_SIZE * OUT_SIZE * DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CW-1:0]      out_row,
  output logic [CW-1:0]      out_col,
  output logic               out_last,
  output logic               busy,
  output logic               overrun
);

  state_e             state;
  logic [FRAME_W-1:0] frame_q;
  logic [DATA_W-1:0]  word;
  logic               beat;
  logic               cnt_last;
  logic               final_beat;
  logic               capture;

  assign beat       = out_valid && out_ready;
  assign final_beat = beat && cnt_last;
  assign capture    = in_valid && ((state == IDLE) || final_beat);

  rc_counter #(
    .SIZE (OUT_SIZE),
    .W    (CW)
  ) u_rc (
    .clk   (clk),
    .rst   (rst),
    .clear (capture || final_beat),
    .en    (beat && !cnt_last),
    .row   (out_row),
    .col   (out_col),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      // NOTE: frame_q is a plain register chain, not a RAM, so clearing it on reset is cheap
      // and keeps out_data at zero until the first capture.
      frame_q   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= in_valid && (state == STREAM) && !final_beat;
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame_q   <= frame_in;
            state     <= STREAM;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        STREAM: begin
          if (beat) begin
            // A frame arriving on the final beat is taken directly, giving no bubble.
            if (final_beat && in_valid) frame_q <= frame_in;
            else                        frame_q <= frame_q >> DATA_W;
            if (final_beat && !in_valid) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word     = frame_q[DATA_W-1:0];
  assign out_last = cnt_last && out_valid;

`ifdef CONV_SER_RELU_EN
  assign out_data = word[DATA_W-1] ? '0 : word;
`else
  assign out_data = word;
`endif

endmodule

// File: tb/tb_conv_result_serializer.sv
// Randomized bench: a 3x3 instance for handshake scenarios and a default 32x32 instance.
module tb_conv_result_serializer;

  localparam int S_OS = 3;
  localparam int S_N  = S_OS * S_OS;
  localparam int S_FW = S_N * 16;
  localparam int L_OS = 32;
  localparam int L_N  = L_OS * L_OS;
  localparam int L_FW = L_N * 16;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic            in_valid, out_ready, out_valid, out_last, busy, overrun;
  logic [S_FW-1:0] frame_in;
  logic [15:0]     out_data;
  logic [1:0]      out_row, out_col;

  logic            in_valid_l, out_ready_l, out_valid_l, out_last_l, busy_l, overrun_l;
  logic [L_FW-1:0] frame_in_l;
  logic [15:0]     out_data_l;
  logic [4:0]      out_row_l, out_col_l;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  conv_result_serializer #(.word_length(8), .kernel_size(5), .image_size(7)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_in(frame_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  conv_result_serializer dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .frame_in(frame_in_l), .out_ready(out_ready_l),
    .out_valid(out_valid_l), .out_data(out_data_l), .out_row(out_row_l), .out_col(out_col_l),
    .out_last(out_last_l), .busy(busy_l), .overrun(overrun_l)
  );

  function automatic logic [15:0] model_word(input logic [15:0] w);
`ifdef CONV_SER_RELU_EN
    return ($signed(w) < 0) ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [S_FW-1:0] rand_frame();
    logic [S_FW-1:0] f;
    for (int i = 0; i < S_N; i++) f[i*16 +: 16] = 16'($urandom);
    return f;
  endfunction

  // Expected beat sequence: word i of the frame at row i/OUT_SIZE, col i%OUT_SIZE.
  task automatic push_frame(input logic [S_FW-1:0] f);
    beat_t e;
    for (int i = 0; i < S_N; i++) begin
      e.data = model_word(f[i*16 +: 16]);
      e.row  = 2'(i / S_OS);
      e.col  = 2'(i % S_OS);
      e.last = (i == S_N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic [S_FW-1:0] f);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    frame_in  = f;
    push_frame(f);
    @(negedge clk);
  endtask

  // Consumes expected beats; mode 1 drives out_ready as 1,0,0,1. Optionally injects in_valid
  // on beat inj_idx, either as an ignored overrun or as a back-to-back frame.
  task automatic drain(input int mode, input int budget, input int max_beats, input int inj_idx,
                       input logic [S_FW-1:0] inj_frame, input bit inj_b2b);
    int          cyc, beats;
    bit          stalled, ov_exp;
    logic [20:0] held, now_o;
    beat_t       e;
    cyc = 0; beats = 0; stalled = 0; ov_exp = 0; held = '0;
    while (exp_q.size() > 0 && beats < max_beats && cyc < budget) begin
      in_valid  = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      now_o = {out_data, out_row, out_col, out_last};
      vectors++;
      if (overrun !== ov_exp) begin
        miscompares++;
        $display("FAIL overrun cyc=%0d got=%b want=%b", cyc, overrun, ov_exp);
      end
      ov_exp = 0;
      if (stalled) begin
        vectors++;
        if (now_o !== held) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, now_o, held);
        end
      end
      vectors++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL valid_busy beat=%0d got valid=%b busy=%b want 1 1", beats, out_valid, busy);
      end
      if (out_ready) begin
        e = exp_q.pop_front();
        vectors++;
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col || out_last !== e.last) begin
          miscompares++;
          $display("FAIL beat%0d got d=%h r=%0d c=%0d l=%b want d=%h r=%0d c=%0d l=%b", beats,
                   out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
        if (beats == inj_idx) begin
          in_valid = 1'b1;
          frame_in = inj_frame;
          if (inj_b2b) push_frame(inj_frame);
          else         ov_exp = 1;
        end
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        held    = now_o;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (beats < max_beats && exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout got beats=%0d want %0d more", beats, exp_q.size());
    end
    if (beats >= max_beats) exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if ({out_valid, busy, out_last, overrun, out_data, out_row, out_col} !== 24'h0) begin
      miscompares++;
      $display("FAIL %s got v=%b b=%b l=%b o=%b d=%h r=%0d c=%0d want all 0", tag, out_valid,
               busy, out_last, overrun, out_data, out_row, out_col);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; frame_in = '0;
    in_valid_l = 1'b0; out_ready_l = 1'b0; frame_in_l = '0;
    repeat (2) @(negedge clk);
    check_idle("reset_small");
    vectors++;
    if ({out_valid_l, busy_l, out_last_l, overrun_l, out_data_l, out_row_l, out_col_l} !== 30'h0) begin
      miscompares++;
      $display("FAIL reset_large got v=%b b=%b d=%h want all 0", out_valid_l, busy_l, out_data_l);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [S_FW-1:0] f;
    for (int i = 0; i < S_N; i++) f[i*16 +: 16] = 16'h0100 + 16'(i);
    start_frame(f);
    drain(0, S_N, 100, -1, '0, 0);
    check_idle("basic_end");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 2; k++) begin
      start_frame(rand_frame());
      drain(1, 40, 100, -1, '0, 0);
      check_idle("bp_end");
    end
  endtask

  task automatic test_overrun();
    start_frame(rand_frame());
    drain(0, S_N, 100, 3, rand_frame(), 0);
    check_idle("overrun_end");
  endtask

  task automatic test_back_to_back();
    start_frame(rand_frame());
    drain(0, 2 * S_N, 100, S_N - 1, rand_frame(), 1);
    check_idle("b2b_end");
  endtask

  task automatic test_mid_reset();
    start_frame(rand_frame());
    drain(0, S_N, 5, -1, '0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    start_frame(rand_frame());
    drain(0, S_N, 100, -1, '0, 0);
    check_idle("after_reset_end");
  endtask

  task automatic test_signed();
    logic [S_FW-1:0] f;
    f = rand_frame();
    f[2*16 +: 16] = 16'hFFF6;
    f[6*16 +: 16] = 16'h8000;
    f[4*16 +: 16] = 16'h7FFF;
    start_frame(f);
    drain(1, 40, 100, -1, '0, 0);
    check_idle("signed_end");
  endtask

  task automatic test_full_size();
    int idx, cyc;
    for (int i = 0; i < L_N; i++) frame_in_l[i*16 +: 16] = 16'(i);
    in_valid_l = 1'b1;
    @(negedge clk);
    in_valid_l = 1'b0;
    idx = 0; cyc = 0;
    while (idx < L_N && cyc < 5000) begin
      out_ready_l = ($urandom_range(0, 3) != 0);
      if (out_valid_l !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL full_valid idx=%0d got=%b want=1", idx, out_valid_l);
      end
      if (out_ready_l) begin
        vectors++;
        if (out_data_l !== 16'(idx) || out_row_l !== 5'(idx / L_OS) ||
            out_col_l !== 5'(idx % L_OS) || out_last_l !== (idx == L_N - 1)) begin
          miscompares++;
          $display("FAIL full_beat%0d got d=%h r=%0d c=%0d l=%b want d=%h r=%0d c=%0d", idx,
                   out_data_l, out_row_l, out_col_l, out_last_l, 16'(idx), idx / L_OS, idx % L_OS);
        end
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready_l = 1'b0;
    vectors++;
    if (idx != L_N || out_valid_l !== 1'b0 || busy_l !== 1'b0) begin
      miscompares++;
      $display("FAIL full_end got beats=%0d valid=%b busy=%b want %0d 0 0", idx, out_valid_l,
               busy_l, L_N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_signed();
    test_full_size();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
